// File: rtl/loader_pkg.sv
// Shared constants and FSM state encodings for the UART program loader.
package loader_pkg;

    localparam logic [7:0]  SYNC_BYTE = 8'hA5;
    localparam int unsigned LEN_W     = 16;

    typedef enum logic [1:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        L_IDLE,
        L_LEN0,
        L_LEN1,
        L_DATA,
        L_CSUM,
        L_DONE
    } ld_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: 2-flop synchroniser plus mid-bit sampling FSM.
// Emits one-cycle byte_valid (good stop bit) or frame_err (bad stop bit).
module uart_rx_byte
    import loader_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned BAUD   = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic       byte_valid,
    output logic       frame_err,
    output logic [7:0] rx_byte
);

    localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic             rx_meta_q, rx_sync_q;
    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;

    // Synchroniser flops reset to the idle-high line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            state_q   <= R_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            rx_meta_q <= uart_rx;
            rx_sync_q <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            R_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (!rx_sync_q) state_d = R_START;
            end
            R_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = rx_sync_q ? R_IDLE : R_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            R_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    if (bit_q == 3'd7) state_d = R_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            R_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = R_IDLE;
                    if (rx_sync_q) valid_d = 1'b1;
                    else           ferr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = R_IDLE;
        endcase
    end

    assign byte_valid = valid_q;
    assign frame_err  = ferr_q;
    assign rx_byte    = shift_q;

endmodule

// File: rtl/uart_program_loader.sv
// Loads a program image from UART into instruction memory while holding the core.
// Define LOADER_CHECKSUM_EN to require a trailing mod-256 checksum byte.
module uart_program_loader
    import loader_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned BAUD        = 115200,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned TIMEOUT_CYC = 5_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              uart_rx,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              cpu_rst_pulse,
    output logic              busy,
    output logic              done,
    output logic              error
);

`ifdef LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [LEN_W:0]   MAX_WORDS = (LEN_W + 1)'(2 ** ADDR_W);

    logic       byte_valid, frame_err;
    logic [7:0] rx_byte;

    uart_rx_byte #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .uart_rx    (uart_rx),
        .byte_valid (byte_valid),
        .frame_err  (frame_err),
        .rx_byte    (rx_byte)
    );

    ld_state_t         state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [ADDR_W-1:0] word_idx_q, word_idx_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [23:0]       pack_q, pack_d;
    logic [7:0]        csum_q, csum_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              hold_q, hold_d;
    logic              pulse_q, pulse_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic              fail, finish, active, last_word;
    logic [LEN_W-1:0]  new_len;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= L_IDLE;
            len_q      <= '0;
            word_idx_q <= '0;
            byte_cnt_q <= '0;
            pack_q     <= '0;
            csum_q     <= '0;
            to_cnt_q   <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            hold_q     <= 1'b0;
            pulse_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_idx_q <= word_idx_d;
            byte_cnt_q <= byte_cnt_d;
            pack_q     <= pack_d;
            csum_q     <= csum_d;
            to_cnt_q   <= to_cnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            hold_q     <= hold_d;
            pulse_q    <= pulse_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_idx_d = word_idx_q;
        byte_cnt_d = byte_cnt_q;
        pack_d     = pack_q;
        csum_d     = csum_q;
        to_cnt_d   = to_cnt_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        hold_d     = hold_q;
        pulse_d    = 1'b0;
        busy_d     = busy_q;
        done_d     = done_q;
        error_d    = error_q;
        fail       = 1'b0;
        finish     = 1'b0;
        new_len    = {rx_byte, len_q[7:0]};
        last_word  = ((LEN_W + 1)'(word_idx_q) + 1'b1) == {1'b0, len_q};
        active     = state_q inside {L_LEN0, L_LEN1, L_DATA, L_CSUM};

        unique case (state_q)
            L_IDLE: begin
                if (byte_valid && rx_byte == SYNC_BYTE) begin
                    busy_d     = 1'b1;
                    hold_d     = 1'b1;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    word_idx_d = '0;
                    byte_cnt_d = '0;
                    csum_d     = '0;
                    state_d    = L_LEN0;
                end
            end
            L_LEN0: begin
                if (byte_valid) begin
                    len_d[7:0] = rx_byte;
                    state_d    = L_LEN1;
                end
            end
            L_LEN1: begin
                if (byte_valid) begin
                    len_d = new_len;
                    if ({1'b0, new_len} > MAX_WORDS) fail = 1'b1;
                    else if (new_len == '0) begin
                        if (CSUM_EN) state_d = L_CSUM;
                        else         finish  = 1'b1;
                    end else begin
                        state_d = L_DATA;
                    end
                end
            end
            L_DATA: begin
                if (byte_valid) begin
                    csum_d     = csum_q + rx_byte;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        we_d       = 1'b1;
                        addr_d     = word_idx_q;
                        wdata_d    = {rx_byte, pack_q};
                        word_idx_d = word_idx_q + 1'b1;
                        if (last_word) begin
                            if (CSUM_EN) state_d = L_CSUM;
                            else         finish  = 1'b1;
                        end
                    end else begin
                        // b0 ends up in the low byte after three shifts.
                        pack_d = {rx_byte, pack_q[23:8]};
                    end
                end
            end
            L_CSUM: begin
                if (byte_valid) begin
                    if (rx_byte == csum_q) finish = 1'b1;
                    else                   fail   = 1'b1;
                end
            end
            L_DONE:  state_d = L_IDLE;
            default: state_d = L_IDLE;
        endcase

        if (active && frame_err) fail = 1'b1;

        // A byte arriving on the expiry cycle clears the counter and wins.
        if (byte_valid || !active) begin
            to_cnt_d = '0;
        end else if (to_cnt_q == TO_LAST) begin
            to_cnt_d = '0;
            fail     = 1'b1;
        end else begin
            to_cnt_d = to_cnt_q + 1'b1;
        end

        // cpu_hold deliberately stays set on failure so a partial image never runs.
        if (fail) begin
            state_d = L_IDLE;
            error_d = 1'b1;
            busy_d  = 1'b0;
        end else if (finish) begin
            state_d = L_DONE;
            pulse_d = 1'b1;
            hold_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
        end
    end

    assign imem_we       = we_q;
    assign imem_addr     = addr_q;
    assign imem_wdata    = wdata_q;
    assign cpu_hold      = hold_q;
    assign cpu_rst_pulse = pulse_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Self-checking bench for uart_program_loader: bit-accurate UART stimulus, image-level model.
module tb_uart_program_loader;

    localparam int unsigned CLK_HZ      = 1_600_000;
    localparam int unsigned BAUD        = 100_000;
    localparam int unsigned CPB         = CLK_HZ / BAUD;
    localparam int unsigned ADDR_W      = 8;
    localparam int unsigned TIMEOUT_CYC = 3000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              uart_rx = 1'b1;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold, cpu_rst_pulse, busy, done, error;

    always #5 clk = ~clk;

    uart_program_loader #(
        .CLK_HZ      (CLK_HZ),
        .BAUD        (BAUD),
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .uart_rx       (uart_rx),
        .imem_we       (imem_we),
        .imem_addr     (imem_addr),
        .imem_wdata    (imem_wdata),
        .cpu_hold      (cpu_hold),
        .cpu_rst_pulse (cpu_rst_pulse),
        .busy          (busy),
        .done          (done),
        .error         (error)
    );

    int checks = 0;
    int errors = 0;

    // Observed write stream and pulse count; expected image words.
    logic [ADDR_W-1:0] got_addr[$];
    logic [31:0]       got_data[$];
    int                pulses = 0;
    logic [31:0]       exp_words[$];
`ifdef LOADER_CHECKSUM_EN
    bit                corrupt_csum = 1'b0;
`endif

    always @(negedge clk) begin
        if (imem_we) begin
            got_addr.push_back(imem_addr);
            got_data.push_back(imem_wdata);
        end
        if (cpu_rst_pulse) pulses++;
    end

    task automatic clear_mon();
        got_addr.delete();
        got_data.delete();
        pulses = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        uart_rx = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(posedge clk);
        end
        uart_rx = stop_ok;
        repeat (CPB) @(posedge clk);
        uart_rx = 1'b1;
    endtask

    // Sends a complete frame for exp_words: SYNC, LEN, little-endian words, optional checksum.
    task automatic send_load(input int max_gap);
        logic [7:0]  q[$];
        logic [7:0]  sum;
        logic [7:0]  b;
        logic [15:0] n;
        logic [31:0] w;
        n   = 16'(exp_words.size());
        sum = 8'h00;
        q.push_back(8'hA5);
        q.push_back(n[7:0]);
        q.push_back(n[15:8]);
        foreach (exp_words[i]) begin
            w = exp_words[i];
            for (int k = 0; k < 4; k++) begin
                b = w[8*k +: 8];
                q.push_back(b);
                sum = sum + b;
            end
        end
`ifdef LOADER_CHECKSUM_EN
        q.push_back(corrupt_csum ? ~sum : sum);
`endif
        foreach (q[i]) begin
            send_byte(q[i], 1'b1);
            repeat ($urandom_range(max_gap)) @(posedge clk);
        end
    endtask

    task automatic settle();
        repeat (3 * CPB) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({imem_we, imem_addr, imem_wdata, cpu_hold, cpu_rst_pulse, busy, done, error} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got we=%b addr=%0h wdata=%0h hold=%b pulse=%b busy=%b done=%b err=%b, want all 0",
                     imem_we, imem_addr, imem_wdata, cpu_hold, cpu_rst_pulse, busy, done, error);
        end
        rst = 1'b0;
        repeat (2 * CPB) @(negedge clk);
        checks++;
        if ({cpu_hold, busy, done, error} !== 4'b0000) begin
            errors++;
            $display("FAIL idle_after_reset: got hold/busy/done/err=%b want 0000",
                     {cpu_hold, busy, done, error});
        end
    endtask

    task automatic test_basic_load();
        clear_mon();
        exp_words = '{32'h00500513, 32'h00A00593};
        send_load(0);
        settle();
        checks++;
        if (got_addr.size() != 2) begin
            errors++;
            $display("FAIL basic_write_count: got %0d want 2", got_addr.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (got_addr[i] !== ADDR_W'(i) || got_data[i] !== exp_words[i]) begin
                    errors++;
                    $display("FAIL basic_write%0d: got addr=%0h data=%08h want addr=%0h data=%08h",
                             i, got_addr[i], got_data[i], i, exp_words[i]);
                end
            end
        end
        checks++;
        if (pulses != 1 || {done, cpu_hold, busy, error} !== 4'b1000) begin
            errors++;
            $display("FAIL basic_status: got pulses=%0d done/hold/busy/err=%b want 1 and 1000",
                     pulses, {done, cpu_hold, busy, error});
        end
    endtask

    task automatic test_zero_len();
        clear_mon();
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        exp_words.delete();
        send_load(0);
        settle();
        checks++;
        if (got_addr.size() != 0 || pulses != 1 || {done, cpu_hold, error} !== 3'b100) begin
            errors++;
            $display("FAIL zero_len: got writes=%0d pulses=%0d done/hold/err=%b want 0, 1, 100",
                     got_addr.size(), pulses, {done, cpu_hold, error});
        end
    endtask

    task automatic test_timeout();
        logic [7:0] bytes[5];
        clear_mon();
        bytes = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22};
        foreach (bytes[i]) send_byte(bytes[i], 1'b1);
        @(negedge clk);
        checks++;
        if ({busy, cpu_hold, done, error} !== 4'b1100) begin
            errors++;
            $display("FAIL timeout_midload: got busy/hold/done/err=%b want 1100",
                     {busy, cpu_hold, done, error});
        end
        repeat (TIMEOUT_CYC + 2 * CPB) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({error, cpu_hold, busy, done} !== 4'b1100 || got_addr.size() != 0 || pulses != 0) begin
            errors++;
            $display("FAIL timeout_abort: got err/hold/busy/done=%b writes=%0d pulses=%0d want 1100, 0, 0",
                     {error, cpu_hold, busy, done}, got_addr.size(), pulses);
        end
    endtask

    task automatic test_frame_err();
        clear_mon();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h3C, 1'b0);
        // The low stop bit can look like a new start; let any such frame finish.
        repeat (12 * CPB) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({error, busy, cpu_hold} !== 3'b101 || got_addr.size() != 0) begin
            errors++;
            $display("FAIL frame_err: got err/busy/hold=%b writes=%0d want 101, 0",
                     {error, busy, cpu_hold}, got_addr.size());
        end
        clear_mon();
        exp_words = '{$urandom()};
        send_load(4);
        settle();
        checks++;
        if (got_addr.size() != 1 || got_data[0] !== exp_words[0] || got_addr[0] !== '0 ||
            {done, error, cpu_hold} !== 3'b100 || pulses != 1) begin
            errors++;
            $display("FAIL recover_after_frame_err: got writes=%0d data=%08h done/err/hold=%b pulses=%0d want 1, %08h, 100, 1",
                     got_addr.size(), (got_data.size() > 0) ? got_data[0] : 32'hx,
                     {done, error, cpu_hold}, pulses, exp_words[0]);
        end
    endtask

    task automatic test_oversize();
        clear_mon();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h01, 1'b1);
        repeat (2) @(negedge clk);
        checks++;
        if ({error, busy, cpu_hold, done} !== 4'b1010 || got_addr.size() != 0) begin
            errors++;
            $display("FAIL oversize_len: got err/busy/hold/done=%b writes=%0d want 1010, 0",
                     {error, busy, cpu_hold, done}, got_addr.size());
        end
    endtask

    task automatic test_reset_midload();
        logic [31:0] w0, w1;
        clear_mon();
        w0 = $urandom();
        w1 = $urandom();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h00, 1'b1);
        for (int k = 0; k < 4; k++) send_byte(w0[8*k +: 8], 1'b1);
        for (int k = 0; k < 2; k++) send_byte(w1[8*k +: 8], 1'b1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({imem_we, imem_addr, imem_wdata, cpu_hold, cpu_rst_pulse, busy, done, error} !== '0) begin
            errors++;
            $display("FAIL reset_midload_outputs: got hold=%b busy=%b done=%b err=%b addr=%0h wdata=%0h want all 0",
                     cpu_hold, busy, done, error, imem_addr, imem_wdata);
        end
        checks++;
        if (got_addr.size() != 1 || got_data[0] !== w0) begin
            errors++;
            $display("FAIL reset_midload_writes: got %0d writes want 1 of %08h", got_addr.size(), w0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (CPB) @(posedge clk);
        clear_mon();
        exp_words = '{$urandom(), $urandom()};
        send_load(3);
        settle();
        checks++;
        if (got_addr.size() != 2 || got_data[0] !== exp_words[0] || got_data[1] !== exp_words[1] ||
            got_addr[1] !== ADDR_W'(1) || done !== 1'b1 || pulses != 1) begin
            errors++;
            $display("FAIL load_after_reset: got writes=%0d done=%b pulses=%0d want 2, 1, 1",
                     got_addr.size(), done, pulses);
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_bad_checksum();
        clear_mon();
        exp_words = '{32'h00500513, 32'h00A00593};
        corrupt_csum = 1'b1;
        send_load(0);
        corrupt_csum = 1'b0;
        settle();
        checks++;
        if ({error, done, cpu_hold} !== 3'b101 || got_addr.size() != 2 || pulses != 0) begin
            errors++;
            $display("FAIL bad_checksum: got err/done/hold=%b writes=%0d pulses=%0d want 101, 2, 0",
                     {error, done, cpu_hold}, got_addr.size(), pulses);
        end
    endtask
`endif

    // Random images with garbage prefix bytes, SYNC-valued data words and random gaps.
    task automatic test_random_loads();
        int n;
        logic [7:0] g;
        for (int iter = 0; iter < 4; iter++) begin
            clear_mon();
            n = $urandom_range(5, 1);
            exp_words.delete();
            for (int i = 0; i < n; i++) exp_words.push_back($urandom());
            exp_words[$urandom_range(n - 1)] = 32'hA5A5A5A5;
            for (int i = 0; i < int'($urandom_range(2)); i++) begin
                g = 8'($urandom_range(255));
                if (g == 8'hA5) g = 8'h5A;
                send_byte(g, 1'b1);
            end
            send_load(20);
            settle();
            checks++;
            if (got_addr.size() != n) begin
                errors++;
                $display("FAIL rand%0d_count: got %0d writes want %0d", iter, got_addr.size(), n);
            end else begin
                for (int i = 0; i < n; i++) begin
                    checks++;
                    if (got_addr[i] !== ADDR_W'(i) || got_data[i] !== exp_words[i]) begin
                        errors++;
                        $display("FAIL rand%0d_word%0d: got addr=%0h data=%08h want addr=%0h data=%08h",
                                 iter, i, got_addr[i], got_data[i], i, exp_words[i]);
                    end
                end
            end
            checks++;
            if (pulses != 1 || {done, error, cpu_hold, busy} !== 4'b1000) begin
                errors++;
                $display("FAIL rand%0d_status: got pulses=%0d done/err/hold/busy=%b want 1, 1000",
                         iter, pulses, {done, error, cpu_hold, busy});
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_zero_len();
        test_timeout();
        test_frame_err();
        test_oversize();
        test_reset_midload();
`ifdef LOADER_CHECKSUM_EN
        test_bad_checksum();
`endif
        test_random_loads();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
